// File: rtl/rsaasip_pkg.sv
// Shared definitions for the RSAASIP 16-bit core: the instruction field layout,
// the opcode encoding and the program-loader state encoding.
package rsaasip_pkg;

   localparam int unsigned ARQ_W   = 16;  // instruction word width
   localparam int unsigned JADDR_W = 13;  // jump-address field width

   // Field positions inside the instruction word
   localparam int OP_MSB  = 15;
   localparam int RD_MSB  = 12;
   localparam int RS1_MSB = 9;
   localparam int RS2_MSB = 6;
   localparam int IMM_W   = 10;

   typedef enum logic [2:0] {
      OP_SET   = 3'd0,
      OP_LDPX  = 3'd1,
      OP_MODEX = 3'd2,
      OP_STPX  = 3'd3,
      OP_CMPEQ = 3'd4,
      OP_JEQ   = 3'd5,
      OP_J     = 3'd6,
      OP_ADD   = 3'd7
   } op_e;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      DONE,
      FULL
   } state_e;

endpackage

// File: rtl/instr_pack.sv
// Combinational field-to-word packer. Places only the fields the opcode uses;
// every other bit is zero, so stray input fields never reach the word.
// Ports:
//   op, srcdest, src1, src2 : opcode and register indices
//   jaddr                   : jump target
//   imm                     : immediate
//   word                    : packed instruction word
module instr_pack
   import rsaasip_pkg::*;
(
   input  logic [2:0]         op,
   input  logic [2:0]         srcdest,
   input  logic [2:0]         src1,
   input  logic [2:0]         src2,
   input  logic [JADDR_W-1:0] jaddr,
   input  logic [IMM_W-1:0]   imm,
   output logic [ARQ_W-1:0]   word
);

   always_comb begin
      word = '0;
      word[OP_MSB -: 3] = op;
      case (op_e'(op))
         OP_SET, OP_ADD: begin
            word[RD_MSB -: 3]  = srcdest;
            word[IMM_W-1:0]    = imm;
         end
         OP_LDPX, OP_STPX: begin
            word[RD_MSB -: 3]  = srcdest;
            word[RS1_MSB -: 3] = src1;
         end
         OP_MODEX, OP_CMPEQ: begin
            word[RD_MSB -: 3]  = srcdest;
            word[RS1_MSB -: 3] = src1;
            word[RS2_MSB -: 3] = src2;
         end
         OP_JEQ, OP_J: begin
            // jump target fills everything below the opcode
            word[JADDR_W-1:0]  = jaddr;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/instr_encoder_loader.sv
// Sequential instruction encoder and program loader. Accepts decoded field
// bundles over valid/ready, packs them into instruction words and streams them
// into instruction memory at an auto-incrementing address.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   start, base_addr      : begin (or restart) a session at base_addr
//   in_valid, in_ready    : bundle handshake
//   op..imm, last         : instruction fields, final-instruction marker
//   mem_we/addr/wdata     : registered instruction memory write port
//   busy, done, overflow  : session status (done/overflow held until start)
//   count                 : words written this session
module instr_encoder_loader
   import rsaasip_pkg::*;
#(
   parameter int unsigned ARQ = 16,
   parameter int unsigned AW  = 13
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           start,
   input  logic [AW-1:0]  base_addr,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [2:0]     op,
   input  logic [2:0]     srcdest,
   input  logic [2:0]     src1,
   input  logic [2:0]     src2,
   input  logic [AW-1:0]  jaddr,
   input  logic [9:0]     imm,
   input  logic           last,
   output logic           mem_we,
   output logic [AW-1:0]  mem_addr,
   output logic [ARQ-1:0] mem_wdata,
   output logic           busy,
   output logic           done,
   output logic           overflow,
   output logic [AW:0]    count
);

   state_e          r_state;
   state_e          w_state_nxt;
   logic            w_accept;
   logic [ARQ-1:0]  w_word;
   logic [AW-1:0]   r_wr_ptr;
   logic [AW:0]     r_count;
   logic            r_mem_we;
   logic [AW-1:0]   r_mem_addr;
   logic [ARQ-1:0]  r_mem_wdata;

   instr_pack u_pack (
      .op      (op),
      .srcdest (srcdest),
      .src1    (src1),
      .src2    (src2),
      .jaddr   (jaddr),
      .imm     (imm),
      .word    (w_word)
   );

   // start wins over a bundle offered in the same cycle
   assign w_accept = (r_state == LOAD) && in_valid && !start;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE, DONE, FULL: begin
            if (start) w_state_nxt = LOAD;
         end
         LOAD: begin
            if (start)                 w_state_nxt = LOAD;
            else if (w_accept && last) w_state_nxt = DONE;
            else if (w_accept && (r_wr_ptr == '1)) w_state_nxt = FULL;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_comb begin
      in_ready = (r_state == LOAD);
      busy     = (r_state == LOAD);
      done     = (r_state == DONE);
      overflow = (r_state == FULL);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr    <= '0;
         r_count     <= '0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
      end else begin
         r_mem_we <= w_accept;
         if (start) begin
            r_wr_ptr <= base_addr;
            r_count  <= '0;
         end else if (w_accept) begin
            r_mem_addr  <= r_wr_ptr;
            r_mem_wdata <= w_word;
            r_count     <= r_count + (AW+1)'(1);
            // pointer saturates at the top; the FSM leaves LOAD there
            if (r_wr_ptr != '1) r_wr_ptr <= r_wr_ptr + AW'(1);
         end
      end
   end

   assign mem_we    = r_mem_we;
   assign mem_addr  = r_mem_addr;
   assign mem_wdata = r_mem_wdata;
   assign count     = r_count;

endmodule

// File: tb/tb_instr_encoder_loader.sv
module tb_instr_encoder_loader;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [12:0] base_addr;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  op, srcdest, src1, src2;
   logic [12:0] jaddr;
   logic [9:0]  imm;
   logic        last;
   logic        mem_we;
   logic [12:0] mem_addr;
   logic [15:0] mem_wdata;
   logic        busy, done, overflow;
   logic [13:0] count;

   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;
   logic [12:0] wr_q[$];
   int          q0;

   always #5 clk = ~clk;

   instr_encoder_loader #(.ARQ(16), .AW(13)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
      .in_valid(in_valid), .in_ready(in_ready), .op(op), .srcdest(srcdest),
      .src1(src1), .src2(src2), .jaddr(jaddr), .imm(imm), .last(last),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .busy(busy), .done(done), .overflow(overflow), .count(count)
   );

   // log of every write address seen on the memory port
   always @(negedge clk) if (mem_we) wr_q.push_back(mem_addr);

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step;
      @(negedge clk);
      #1;
   endtask

   task automatic idle_in;
      start = 0; in_valid = 0; last = 0;
      op = 0; srcdest = 0; src1 = 0; src2 = 0; jaddr = 0; imm = 0;
   endtask

   task automatic bundle(input logic [2:0] o, input logic [2:0] rd, input logic [2:0] s1,
                         input logic [2:0] s2, input logic [12:0] ja, input logic [9:0] im,
                         input logic l);
      in_valid = 1; op = o; srcdest = rd; src1 = s1; src2 = s2; jaddr = ja; imm = im; last = l;
   endtask

   task automatic begin_session(input logic [12:0] b);
      start = 1; base_addr = b;
      step;
      start = 0;
   endtask

   initial begin
      rst_n = 0; base_addr = 0;
      idle_in;
      step; step;
      check("rst_we",    mem_we,    0);
      check("rst_addr",  mem_addr,  0);
      check("rst_wdata", mem_wdata, 0);
      check("rst_ready", in_ready,  0);
      check("rst_busy",  busy,      0);
      check("rst_done",  done,      0);
      check("rst_ovf",   overflow,  0);
      check("rst_count", count,     0);
      rst_n = 1;
      step;
      check("idle_ready", in_ready, 0);

      // single SET, last
      begin_session(13'h0000);
      check("t1_busy",  busy,     1);
      check("t1_ready", in_ready, 1);
      check("t1_cnt0",  count,    0);
      bundle(3'd0, 3'd3, 3'd0, 3'd0, 13'h0, 10'h155, 1);
      step; idle_in;
      check("t1_we",    mem_we,    1);
      check("t1_addr",  mem_addr,  13'h0000);
      check("t1_data",  mem_wdata, 16'h0D55);
      check("t1_done",  done,      1);
      check("t1_count", count,     1);
      check("t1_ready", in_ready,  0);
      step;
      check("t1_we_off",  mem_we, 0);
      check("t1_done_hold", done, 1);

      // back-to-back MODEX, CMPEQ
      begin_session(13'h0010);
      check("t2_done_clr", done, 0);
      bundle(3'd2, 3'd1, 3'd2, 3'd5, 13'h1FFF, 10'h3FF, 0);
      step;
      check("t2_we0",   mem_we,    1);
      check("t2_addr0", mem_addr,  13'h0010);
      check("t2_data0", mem_wdata, 16'h4550);
      check("t2_cnt0",  count,     1);
      bundle(3'd4, 3'd4, 3'd0, 3'd7, 13'h1FFF, 10'h3FF, 1);
      step; idle_in;
      check("t2_we1",   mem_we,    1);
      check("t2_addr1", mem_addr,  13'h0011);
      check("t2_data1", mem_wdata, 16'h9070);
      check("t2_cnt1",  count,     2);
      check("t2_done",  done,      1);

      // J, ADD, LDPX, JEQ with stray fields
      begin_session(13'h0020);
      bundle(3'd6, 3'd5, 3'd7, 3'd3, 13'h1ABC, 10'h3FF, 0);
      step;
      check("t3_j_addr", mem_addr,  13'h0020);
      check("t3_j_data", mem_wdata, 16'hDABC);
      bundle(3'd7, 3'd7, 3'd5, 3'd5, 13'h1FFF, 10'h2AA, 0);
      step;
      check("t3_add_data", mem_wdata, 16'hFEAA);
      bundle(3'd1, 3'd5, 3'd4, 3'd7, 13'h1FFF, 10'h3FF, 0);
      step;
      check("t3_ldpx_data", mem_wdata, 16'h3600);
      bundle(3'd5, 3'd7, 3'd7, 3'd7, 13'h0005, 10'h3FF, 1);
      step; idle_in;
      check("t3_jeq_addr", mem_addr,  13'h0023);
      check("t3_jeq_data", mem_wdata, 16'hA005);
      check("t3_count",    count,     4);

      // address space exhaustion
      begin_session(13'h1FFE);
      q0 = wr_q.size();
      bundle(3'd3, 3'd2, 3'd6, 3'd0, 13'h0, 10'h0, 0);
      step;
      check("t4_addr0", mem_addr,  13'h1FFE);
      check("t4_data0", mem_wdata, 16'h6B00);
      check("t4_ovf0",  overflow,  0);
      step;
      check("t4_we1",    mem_we,    1);
      check("t4_addr1",  mem_addr,  13'h1FFF);
      check("t4_data1",  mem_wdata, 16'h6B00);
      check("t4_ovf",    overflow,  1);
      check("t4_ready",  in_ready,  0);
      check("t4_cnt",    count,     2);
      step; idle_in;
      check("t4_we3",    mem_we,    0);
      check("t4_cnt3",   count,     2);
      check("t4_nwr",    wr_q.size() - q0, 2);
      check("t4_ovf_hold", overflow, 1);

      // reset in the cycle of an accept
      begin_session(13'h0040);
      bundle(3'd0, 3'd1, 3'd0, 3'd0, 13'h0, 10'h001, 0);
      step;
      check("t5_we_pre", mem_we, 1);
      q0 = wr_q.size();
      bundle(3'd0, 3'd2, 3'd0, 3'd0, 13'h0, 10'h002, 0);
      #2 rst_n = 0;
      #1;
      check("t5_we",    mem_we,    0);
      check("t5_addr",  mem_addr,  0);
      check("t5_data",  mem_wdata, 0);
      check("t5_cnt",   count,     0);
      check("t5_busy",  busy,      0);
      check("t5_ready", in_ready,  0);
      step; step;
      rst_n = 1;
      step; step;
      check("t5_we_post", mem_we, 0);
      check("t5_nwr",     wr_q.size() - q0, 0);
      idle_in;
      begin_session(13'h0050);
      bundle(3'd0, 3'd1, 3'd0, 3'd0, 13'h0, 10'h001, 1);
      step; idle_in;
      check("t5_re_addr", mem_addr,  13'h0050);
      check("t5_re_data", mem_wdata, 16'h0401);
      check("t5_re_done", done,      1);

      // restart during LOAD drops the concurrent bundle
      begin_session(13'h0060);
      q0 = wr_q.size();
      bundle(3'd4, 3'd4, 3'd0, 3'd7, 13'h0, 10'h0, 0);
      step;
      check("t6_addr0", mem_addr, 13'h0060);
      start = 1; base_addr = 13'h0070;
      bundle(3'd0, 3'd7, 3'd0, 3'd0, 13'h0, 10'h3FF, 0);
      step; start = 0;
      check("t6_we_drop", mem_we,   0);
      check("t6_cnt0",    count,    0);
      check("t6_busy",    busy,     1);
      bundle(3'd3, 3'd2, 3'd6, 3'd0, 13'h0, 10'h0, 1);
      step; idle_in;
      check("t6_we",   mem_we,    1);
      check("t6_addr", mem_addr,  13'h0070);
      check("t6_data", mem_wdata, 16'h6B00);
      check("t6_cnt",  count,     1);
      check("t6_nwr",  wr_q.size() - q0, 2);

      step;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
